booth_divider: RTL and testbench

//   Sequential signed divider, the inverse of the 4-bit Booth multiplier (Z = X*Y).

---
 rtl/booth_divider.sv | 163 ++++++++++++++++
 tb/tb_booth_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | booth_divider                                                             |
// | Sequential signed restoring divider: Z (2N bits) / X (N bits) -> Y, R.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module booth_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] Z,
  input  logic [N-1:0]   X,
  output logic [N-1:0]   Y,
  output logic [N-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dbz
);

  localparam int              C_CW   = $clog2(2*N+1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(2*N);
  localparam logic [2*N-1:0]  C_QPOS = (2*N)'(2**(N-1)-1);
  localparam logic [2*N-1:0]  C_QNEG = (2*N)'(2**(N-1));

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_FIX  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [N:0]      rem_q, rem_d;
  logic [2*N-1:0]  quo_q, quo_d;
  logic [N:0]      xmag_q, xmag_d;
  logic            neg_q, neg_d;
  logic            sz_q, sz_d;
  logic            xz_q, xz_d;
  logic [N-1:0]    y_q, y_d;
  logic [N-1:0]    r_q, r_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [2*N-1:0]  w_zmag;
  logic [N:0]      w_xext;
  logic [N:0]      w_xmag;
  logic [N+1:0]    w_rem_sh;
  logic [N+1:0]    w_trial;
  logic [N-1:0]    w_ylow;
  logic [N-1:0]    w_rsig;
  logic            w_ovf;

  // Unsigned view of -2^(2N-1) is 2^(2N-1), so 2N bits suffice for |Z|.
  assign w_zmag   = Z[2*N-1] ? (~Z + 1'b1) : Z;
  assign w_xext   = {X[N-1], X};
  assign w_xmag   = X[N-1] ? (~w_xext + 1'b1) : w_xext;
  assign w_rem_sh = {rem_q, quo_q[2*N-1]};
  assign w_trial  = w_rem_sh - {1'b0, xmag_q};
  assign w_ylow   = neg_q ? (~quo_q[N-1:0] + 1'b1) : quo_q[N-1:0];
  assign w_rsig   = sz_q ? (~rem_q[N-1:0] + 1'b1) : rem_q[N-1:0];
  assign w_ovf    = neg_q ? (quo_q > C_QNEG) : (quo_q > C_QPOS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      xmag_q  <= '0;
      neg_q   <= 1'b0;
      sz_q    <= 1'b0;
      xz_q    <= 1'b0;
      y_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      xmag_q  <= xmag_d;
      neg_q   <= neg_d;
      sz_q    <= sz_d;
      xz_q    <= xz_d;
      y_q     <= y_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // RUN spends one extra cycle after the 2N-th iteration so latency is 2N+2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = C_RUN;
      C_RUN:   if (cnt_q == C_LAST) state_d = C_FIX;
      C_FIX:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    xmag_d = xmag_q;
    neg_d  = neg_q;
    sz_d   = sz_q;
    xz_d   = xz_q;
    y_d    = y_q;
    r_d    = r_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    busy_d = (state_d != C_IDLE);
    done_d = (state_q == C_FIX);
    case (state_q)
      C_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = w_zmag;
          xmag_d = w_xmag;
          neg_d  = Z[2*N-1] ^ X[N-1];
          sz_d   = Z[2*N-1];
          xz_d   = (X == '0);
        end
      end
      C_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != C_LAST) begin
          quo_d = {quo_q[2*N-2:0], ~w_trial[N+1]};
          rem_d = w_trial[N+1] ? w_rem_sh[N:0] : w_trial[N:0];
        end
      end
      C_FIX: begin
        dbz_d = xz_q;
        y_d   = xz_q ? '0 : w_ylow;
        r_d   = xz_q ? '0 : w_rsig;
        ovf_d = !xz_q && w_ovf;
      end
      default: ;
    endcase
  end

  assign Y    = y_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_booth_divider                                                          |
// | Randomized and sweep bench for booth_divider against a C-style model.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_booth_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] Z;
  logic [3:0] X;
  logic [3:0] Y;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       dbz;

  int n_checks = 0;
  int n_errors = 0;

  booth_divider #(.N(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Z     (Z),
    .X     (X),
    .Y     (Y),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division straight from the arithmetic definition.
  task automatic model(input logic [7:0] z, input logic [3:0] x,
                       output logic [3:0] ey, output logic [3:0] er,
                       output logic eo, output logic ed);
    int zi, xi, q, r;
    zi = int'($signed(z));
    xi = int'($signed(x));
    if (xi == 0) begin
      ey = 4'd0; er = 4'd0; eo = 1'b0; ed = 1'b1;
    end else begin
      q  = zi / xi;
      r  = zi % xi;
      ey = q[3:0];
      er = r[3:0];
      eo = (q < -8) || (q > 7);
      ed = 1'b0;
    end
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_and_check(input logic [7:0] z, input logic [3:0] x, input bit aligned);
    int lat;
    logic [3:0] ey, er;
    logic eo, ed;
    if (!aligned) @(negedge clk);
    Z = z; X = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    chk($sformatf("busy_on z=%h x=%h", z, x), busy, 1);
    wait_done(lat);
    chk($sformatf("latency z=%h x=%h", z, x), lat, 10);
    model(z, x, ey, er, eo, ed);
    chk($sformatf("Y z=%h x=%h", z, x), Y, ey);
    chk($sformatf("R z=%h x=%h", z, x), R, er);
    chk($sformatf("ovf z=%h x=%h", z, x), ovf, eo);
    chk($sformatf("dbz z=%h x=%h", z, x), dbz, ed);
    chk($sformatf("busy_off z=%h x=%h", z, x), busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] dz [6];
    logic [3:0] dx [6];
    int lat;
    bit seen;

    dz = '{8'd42, 8'hD5, 8'h2B, 8'd100, 8'h80, 8'd17};
    dx = '{4'd6,  4'd6,  4'hA,  4'd3,   4'hF,  4'd0};

    rst_n = 1'b0; start = 1'b0; Z = '0; X = '0;
    repeat (3) @(negedge clk);
    chk("rst_Y", Y, 0);
    chk("rst_R", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_and_check(dz[i], dx[i], 1'b0);
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", done, 0);
      end
    end

    // start pulsed during RUN must not disturb the operation in flight
    @(negedge clk);
    Z = 8'd42; X = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    repeat (3) begin @(negedge clk); lat++; end
    Z = 8'd100; X = 4'd3; start = 1'b1;
    @(negedge clk);
    lat++; start = 1'b0;
    wait_done(lat);
    chk("ign_latency", lat, 10);
    chk("ign_Y", Y, 7);
    chk("ign_R", R, 0);
    chk("ign_ovf", ovf, 0);
    seen = 1'b0;
    repeat (14) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    chk("ign_no_second_op", seen, 0);

    // reset during RUN discards the operation and clears outputs
    Z = 8'hD5; X = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_Y", Y, 0);
    chk("mid_rst_R", R, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("mid_rst_no_done", seen, 0);

    // back-to-back: new start on the done cycle
    run_and_check(8'd42, 4'd6, 1'b0);
    run_and_check(8'hD5, 4'd6, 1'b1);

    for (int i = -8; i < 8; i++) begin
      if (i != 0) begin
        for (int j = -8; j < 8; j++) begin
          int p;
          p = i * j;
          run_and_check(p[7:0], i[3:0], 1'b0);
        end
      end
    end

    for (int z = 0; z < 256; z++) begin
      for (int x = 1; x < 16; x++) begin
        run_and_check(z[7:0], x[3:0], 1'b0);
      end
    end

    for (int k = 0; k < 200; k++) begin
      logic [7:0] rz;
      logic [3:0] rx;
      rz = 8'($urandom_range(0, 255));
      rx = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_and_check(rz, rx, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
